// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stage-register bit positions
// in the stall/flush vectors and the redirect FSM state encoding.
package pipe_ctrl_pkg;

  localparam int NSTG         = 5;
  localparam int STALL_PC     = 0;
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_stall_dec.sv
// Combinational priority decoder: exception > branch > oldest stall requester,
// with the pending-redirect overlay that holds the PC and bubbles IF/ID.
module pipe_ctrl_stall_dec
  import pipe_ctrl_pkg::*;
(
  input  logic            stallreq_if_i,
  input  logic            stallreq_id_i,
  input  logic            stallreq_ex_i,
  input  logic            stallreq_mem_i,
  input  logic            branch_valid_i,
  input  logic            excp_valid_i,
  input  logic            wait_st_i,
  output logic [NSTG-1:0] stall_o,
  output logic [NSTG-1:0] flush_o
);

  always_comb begin
    stall_o = '0;
    flush_o = '0;
    if (excp_valid_i) begin
      flush_o[STALL_MEM_WB:STALL_IF_ID] = '1;
    end else begin
      // The oldest requester freezes everything upstream and bubbles its successor.
      if (stallreq_mem_i) begin
        stall_o[STALL_EX_MEM:STALL_PC] = '1;
        flush_o[STALL_MEM_WB]          = 1'b1;
      end else if (stallreq_ex_i) begin
        stall_o[STALL_ID_EX:STALL_PC] = '1;
        flush_o[STALL_EX_MEM]         = 1'b1;
      end else if (stallreq_id_i) begin
        stall_o[STALL_IF_ID:STALL_PC] = '1;
        flush_o[STALL_ID_EX]          = 1'b1;
      end else if (stallreq_if_i) begin
        stall_o[STALL_PC]    = 1'b1;
        flush_o[STALL_IF_ID] = 1'b1;
      end

      // A MEM stall outranks the branch; younger requesters are squashed by it.
      if (branch_valid_i && !wait_st_i) begin
        if (!stallreq_mem_i) begin
          stall_o = '0;
          flush_o = '0;
        end
        flush_o[STALL_ID_EX] = 1'b1;
        flush_o[STALL_IF_ID] = 1'b1;
      end

      if (wait_st_i) begin
        stall_o[STALL_PC]    = 1'b1;
        flush_o[STALL_IF_ID] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller top: stall/flush decode, redirect FSM holding the new PC
// toward IF until accepted, and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             branch_valid,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             excp_valid,
  input  logic [PC_W-1:0]  excp_target,
  input  logic             redirect_ready,
  output logic [NSTG-1:0]  stall,
  output logic [NSTG-1:0]  flush,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stall_cycles
);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  rpc_q, rpc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NSTG-1:0]  dec_stall, dec_flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  pipe_ctrl_stall_dec u_stall_dec (
    .stallreq_if_i  (stallreq_if),
    .stallreq_id_i  (stallreq_id),
    .stallreq_ex_i  (stallreq_ex),
    .stallreq_mem_i (stallreq_mem),
    .branch_valid_i (branch_valid),
    .excp_valid_i   (excp_valid),
    .wait_st_i      (state_q == WAIT),
    .stall_o        (dec_stall),
    .flush_o        (dec_flush)
  );

  assign stall          = rst ? dec_stall : '0;
  assign flush          = rst ? dec_flush : '0;
  assign redirect_valid = (state_q == WAIT);
  assign redirect_pc    = rpc_q;
  assign stall_cycles   = cnt_q;

  // Next state: a new exception always wins and overwrites a pending target.
  always_comb begin
    state_d = state_q;
    rpc_d   = rpc_q;
    cnt_d   = (|dec_stall) ? sat_inc(cnt_q) : cnt_q;
    if (excp_valid) begin
      state_d = WAIT;
      rpc_d   = excp_target;
    end else if (state_q == IDLE && branch_valid && !stallreq_mem) begin
      state_d = WAIT;
      rpc_d   = branch_target;
    end else if (state_q == WAIT && redirect_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rpc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rpc_q   <= rpc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: decode table, directed redirect sequences and random
// traffic against a behavioural model; a narrow-counter instance shows saturation.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sif, sid, sex, smem, bv, ev, rr;
  logic [31:0] bt, et;

  logic [4:0]  stall, flush, stall_b, flush_b;
  logic        rv, rv_b;
  logic [31:0] rpc, rpc_b, sc;
  logic [3:0]  sc4;

  int n_vec = 0;
  int n_err = 0;

  bit              m_pend;
  logic [31:0]     m_pc;
  longint unsigned m_cnt;
  int unsigned     m_cnt4;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
    .branch_valid(bv), .branch_target(bt), .excp_valid(ev), .excp_target(et),
    .redirect_ready(rr), .stall(stall), .flush(flush),
    .redirect_valid(rv), .redirect_pc(rpc), .stall_cycles(sc)
  );

  pipe_ctrl #(.PC_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
    .branch_valid(bv), .branch_target(bt), .excp_valid(ev), .excp_target(et),
    .redirect_ready(rr), .stall(stall_b), .flush(flush_b),
    .redirect_valid(rv_b), .redirect_pc(rpc_b), .stall_cycles(sc4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected decode: the oldest requesting stage j (IF=0..MEM=3) holds
  // registers 0..j and bubbles register j+1.
  function automatic void model_comb(output logic [4:0] s, output logic [4:0] f);
    int j;
    j = -1;
    if (smem) j = 3; else if (sex) j = 2; else if (sid) j = 1; else if (sif) j = 0;
    s = '0;
    f = '0;
    if (!rst) return;
    if (ev) begin
      f = 5'b11110;
      return;
    end
    if (j >= 0) begin
      s = 5'((1 << (j + 1)) - 1);
      f = 5'(1 << (j + 1));
    end
    if (bv && !m_pend) begin
      if (j == 3) f = f | 5'b00110;
      else begin
        s = '0;
        f = 5'b00110;
      end
    end
    if (m_pend) begin
      s = s | 5'b00001;
      f = f | 5'b00010;
    end
  endfunction

  task automatic model_reset();
    m_pend = 1'b0;
    m_pc   = '0;
    m_cnt  = 0;
    m_cnt4 = 0;
  endtask

  task automatic model_clk();
    logic [4:0] s, f;
    if (!rst) begin
      model_reset();
      return;
    end
    model_comb(s, f);
    if (|s) begin
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (ev) begin
      m_pend = 1'b1;
      m_pc   = et;
    end else if (!m_pend && bv && !smem) begin
      m_pend = 1'b1;
      m_pc   = bt;
    end else if (m_pend && rr) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic sample();
    logic [4:0] s, f;
    @(negedge clk);
    model_comb(s, f);
    chk("stall", {59'd0, stall}, {59'd0, s});
    chk("flush", {59'd0, flush}, {59'd0, f});
    chk("redirect_valid", {63'd0, rv}, {63'd0, m_pend});
    chk("redirect_pc", {32'd0, rpc}, {32'd0, m_pc});
    chk("stall_cycles", {32'd0, sc}, m_cnt);
    chk("stall_cycles_w4", {60'd0, sc4}, {32'd0, m_cnt4});
    chk("narrow_inst_ctl", {21'd0, stall_b, flush_b, rv_b, rpc_b}, {21'd0, s, f, m_pend, m_pc});
  endtask

  task automatic step();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic idle_in();
    {sif, sid, sex, smem, bv, ev, rr} = '0;
    bt = '0;
    et = '0;
  endtask

  typedef struct {
    logic [3:0] req;   // {mem, ex, id, if}
    logic [4:0] s;
    logic [4:0] f;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{4'b0000, 5'b00000, 5'b00000};
    tbl[1] = '{4'b0001, 5'b00001, 5'b00010};
    tbl[2] = '{4'b0010, 5'b00011, 5'b00100};
    tbl[3] = '{4'b0011, 5'b00011, 5'b00100};
    tbl[4] = '{4'b0100, 5'b00111, 5'b01000};
    tbl[5] = '{4'b1000, 5'b01111, 5'b10000};
    tbl[6] = '{4'b1111, 5'b01111, 5'b10000};

    rst = 1'b0;
    model_reset();
    idle_in();

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      {sif, sid, sex, smem, bv, ev, rr} = 7'($urandom);
      bt = $urandom;
      et = $urandom;
      sample();
      chk("reset_stall", {59'd0, stall}, 64'd0);
      chk("reset_flush", {59'd0, flush}, 64'd0);
      step();
    end
    idle_in();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      step();
    end
    sample();
    chk("idle_counter", {32'd0, sc}, 64'd0);
    step();

    // EX stall for four cycles
    sex = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("ex_stall", {59'd0, stall}, 64'b00111);
      chk("ex_flush", {59'd0, flush}, 64'b01000);
      step();
    end
    sex = 1'b0;
    sample();
    chk("ex_count", {32'd0, sc}, 64'd4);
    step();

    // Decode table
    for (int i = 0; i < 7; i++) begin
      {smem, sex, sid, sif} = tbl[i].req;
      sample();
      chk($sformatf("tbl%0d_stall", i), {59'd0, stall}, {59'd0, tbl[i].s});
      chk($sformatf("tbl%0d_flush", i), {59'd0, flush}, {59'd0, tbl[i].f});
      step();
    end
    idle_in();

    // Exception with delayed acceptance
    ev = 1'b1;
    et = 32'h1C00_0100;
    sample();
    chk("excp_flush", {59'd0, flush}, 64'b11110);
    chk("excp_stall", {59'd0, stall}, 64'd0);
    step();
    ev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rr = (i == 3);
      sample();
      chk("excp_rv", {63'd0, rv}, 64'd1);
      chk("excp_pc", {32'd0, rpc}, 64'h1C00_0100);
      chk("excp_pc_hold", {63'd0, stall[0]}, 64'd1);
      step();
    end
    rr = 1'b0;
    sample();
    chk("excp_accepted", {63'd0, rv}, 64'd0);
    step();

    // Branch blocked by MEM stall, then latched
    bv = 1'b1;
    bt = 32'h1C00_0040;
    smem = 1'b1;
    sample();
    chk("brmem_stall", {59'd0, stall}, 64'b01111);
    chk("brmem_flush", {59'd0, flush}, 64'b10110);
    step();
    smem = 1'b0;
    sample();
    chk("br_flush", {59'd0, flush}, 64'b00110);
    chk("br_not_yet", {63'd0, rv}, 64'd0);
    step();
    bv = 1'b0;
    sample();
    chk("br_rv", {63'd0, rv}, 64'd1);
    chk("br_pc", {32'd0, rpc}, 64'h1C00_0040);
    step();
    rr = 1'b1;
    sample();
    step();
    idle_in();

    // Exception overwrite coinciding with acceptance
    ev = 1'b1;
    et = 32'h100;
    sample();
    step();
    et = 32'h200;
    rr = 1'b1;
    sample();
    step();
    idle_in();
    sample();
    chk("ovr_rv", {63'd0, rv}, 64'd1);
    chk("ovr_pc", {32'd0, rpc}, 64'h200);
    step();

    // Asynchronous reset while a redirect is pending
    #2;
    rst = 1'b0;
    #1;
    chk("async_rv", {63'd0, rv}, 64'd0);
    chk("async_pc", {32'd0, rpc}, 64'd0);
    chk("async_cnt", {32'd0, sc}, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      sif  = ($urandom_range(3) == 0);
      sid  = ($urandom_range(3) == 0);
      sex  = ($urandom_range(5) == 0);
      smem = ($urandom_range(5) == 0);
      bv   = ($urandom_range(5) == 0);
      ev   = ($urandom_range(9) == 0);
      rr   = ($urandom_range(1) == 0);
      bt   = $urandom;
      et   = $urandom;
      sample();
      step();
    end

    // Narrow counter must sit at all-ones after sustained stalls
    idle_in();
    smem = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample();
      step();
    end
    sample();
    chk("sat_w4", {60'd0, sc4}, 64'hF);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core (IF, ID, EX, MEM, WB).
- Merges per-stage stall requests, branch redirects and exception/ertn redirects into per-stage-register stall and flush vectors; the MEM/WB stage register consumes bit 4.
- Owns a registered redirect FSM that holds the new PC toward IF until it is accepted.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- PC_W, 32, width of PC/redirect target
- CNT_W, 32, width of stall-cycle counter

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- stallreq_if  in  1  IF stage requests stall
- stallreq_id  in  1  ID stage requests stall
- stallreq_ex  in  1  EX stage requests stall (e.g. divider busy)
- stallreq_mem  in  1  MEM stage requests stall (e.g. dcache miss)
- branch_valid  in  1  EX resolved a mispredicted branch this cycle
- branch_target  in  PC_W  branch redirect PC
- excp_valid  in  1  MEM commits exception or ertn this cycle
- excp_target  in  PC_W  exception entry / ertn return PC
- redirect_ready  in  1  IF accepts redirect
- stall  out  5  [0]=pc, [1]=if_id, [2]=id_ex, [3]=ex_mem, [4]=mem_wb; 1 = hold
- flush  out  5  same bit mapping; 1 = load bubble
- redirect_valid  out  1  redirect PC pending
- redirect_pc  out  PC_W  redirect target
- stall_cycles  out  CNT_W  cycles with any stall bit set

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, redirect_valid=0, redirect_pc=0, stall_cycles=0. stall and flush are combinational and evaluate to 0 while in reset.
- Stall decode (combinational), based on the oldest requester:
  - stallreq_mem → stall=5'b01111, flush[4]=1 (bubble into mem_wb)
  - else stallreq_ex → 5'b00111, flush[3]=1
  - else stallreq_id → 5'b00011, flush[2]=1
  - else stallreq_if → 5'b00001, flush[1]=1
- Priority: excp_valid > branch_valid > stall requests.
- Exception in cycle T (any state):
  - Cycle T: flush=5'b11110, stall=0.
  - Register redirect_pc=excp_target; state→WAIT; redirect_valid=1 from T+1.
- Branch in cycle T (no excp_valid):
  - Cycle T: flush=5'b00110, stall=0.
  - Register branch_target; state→WAIT.
  - A simultaneous stallreq_mem still stalls: stall=5'b01111, flush[4]=1, flush[2:1]=2'b11. The branch is latched only when stallreq_mem=0.
- FSM:
  - IDLE → WAIT on latched excp/branch.
  - WAIT → IDLE on redirect_valid & redirect_ready.
  - In WAIT: stall[0]=1 and flush[1]=1 every cycle.
  - New excp_valid in WAIT overwrites redirect_pc (latest wins) and stays in WAIT.
  - branch_valid in WAIT is ignored.
- Handshake:
  - redirect_pc is stable while redirect_valid=1 and ready=0 (except an exception overwrite).
  - Acceptance in the same cycle as a new excp_valid keeps WAIT and loads the new target.
- Counter: increments when |stall is 1 in a cycle; saturates at all-ones, never wraps.
- Reset mid-WAIT: returns to IDLE immediately and drops redirect_valid asynchronously.

Decomposition:
- Shared defines:
  - stall/flush bit indices (STALL_PC … STALL_MEM_WB)
  - state encodings IDLE=1'b0, WAIT=1'b1
  - width of the stall vector
- Sub-module: pipe_ctrl_stall_dec, a combinational priority decoder producing the stall/flush vectors. The FSM and counter stay in the top.

Test Plan:
- Reset: rst=0 with random inputs → stall=0, flush=0, redirect_valid=0, stall_cycles=0; release, idle 3 cycles → counter stays 0.
- stallreq_ex=1 for 4 cycles → stall=5'b00111, flush=5'b01000 each cycle; stall_cycles=4.
- excp_valid=1, excp_target=0x1C00_0100 at T, redirect_ready=0 for 3 cycles → flush=5'b11110 at T; redirect_valid=1 with pc 0x1C00_0100 T+1..T+4; stall[0]=1; ready=1 at T+4 → IDLE at T+5.
- branch_valid=1, target 0x1C00_0040, plus stallreq_mem=1 in the same cycle → stall=5'b01111, no latch; next cycle branch only → latched, redirect_valid=1.
- In WAIT with pc A=0x100, excp_valid with B=0x200 coinciding with redirect_ready=1 → stays WAIT, redirect_pc=0x200.
- Force stall_cycles to 0xFFFF_FFFE, stall 3 cycles → holds 0xFFFF_FFFF.
